// File: rtl/stream_block_reader.sv
// rtl/stream_block_reader.sv - stream sink that captures a block of words into a buffer with registered readback
// Optional pseudo-random ready throttling is enabled by defining STREAM_READER_THROTTLE_EN.
module stream_block_reader #(
  parameter int          WIDTH          = 8,
  parameter int          MAX_BLOCK_SIZE = 1024,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1,
  localparam int         CW             = $clog2(MAX_BLOCK_SIZE + 1),
  localparam int         AW             = $clog2(MAX_BLOCK_SIZE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] stream_s_data_i,
  input  logic             stream_s_valid_i,
  output logic             stream_s_ready_o,
  input  logic             start_i,
  input  logic [CW-1:0]    length_i,
  input  logic [7:0]       rate_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [CW-1:0]    count_o,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o
);

  localparam logic [CW-1:0] MAX_LEN = CW'(MAX_BLOCK_SIZE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    len_q, len_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CW-1:0]    count_inc;
  logic             gate_q, gate_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             mem_we;
  logic [AW-1:0]    mem_waddr;

  logic [WIDTH-1:0] mem [MAX_BLOCK_SIZE];

`ifdef STREAM_READER_THROTTLE_EN
  logic [15:0] lfsr_q, lfsr_d;
  logic        lfsr_fb;

  // Fibonacci LFSR, taps 16/14/13/11, free-running from reset
  always_comb begin
    lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    lfsr_d  = {lfsr_q[14:0], lfsr_fb};
    gate_d  = (rate_i == 8'hFF) || (lfsr_q[7:0] < rate_i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end
`else
  logic unused_rate;
  assign unused_rate = ^rate_i;
  assign gate_d      = 1'b1;
`endif

  assign count_inc = count_q + CW'(1);
  assign rd_data_d = mem[rd_addr_i];

  always_comb begin
    state_d          = state_q;
    len_d            = len_q;
    count_d          = count_q;
    stream_s_ready_o = 1'b0;
    busy_o           = 1'b0;
    done_o           = 1'b0;
    mem_we           = 1'b0;
    mem_waddr        = count_q[AW-1:0];
    case (state_q)
      IDLE: begin
        if (start_i) begin
          count_d = '0;
          len_d   = (length_i > MAX_LEN) ? MAX_LEN : length_i;
          state_d = (length_i == '0) ? DONE : RECV;
        end
      end
      RECV: begin
        busy_o           = 1'b1;
        stream_s_ready_o = gate_q;
        if (stream_s_valid_i && gate_q) begin
          mem_we  = ~rst;
          count_d = count_inc;
          // Leaving RECV on the final word drops ready before another can be taken
          if (count_inc == len_q) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      len_q     <= '0;
      count_q   <= '0;
      gate_q    <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      count_q   <= count_d;
      gate_q    <= gate_d;
      rd_data_q <= rd_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= stream_s_data_i;
    end
  end

  assign count_o   = count_q;
  assign rd_data_o = rd_data_q;

endmodule
